// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage owning the PC, issuing icache reads and driving the IF/ID (FD) latch.
// Build option: define FETCH_HALT_STOP_EN to stop fetching after a HALT word.
// Ports:
//   CLK, nRST               clock, asynchronous active-low reset
//   ihit, imemload          icache hit and read data for imemaddr
//   imemREN, imemaddr       icache read enable and address (= pc)
//   stall, flush            hazard unit: hold PC/FD, bubble FD
//   redirect, redirect_pc   EX-resolved branch/jump target
//   fd_instr, fd_pc_plus_4  FD latch payload (FD_t instr / pc_plus_4)
//   fd_valid, fetch_halted  FD holds a real instruction; fetch stopped on HALT
module fetch_stage #(
    parameter logic [31:0] PC_INIT    = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fd_instr,
    output logic [31:0] fd_pc_plus_4,
    output logic        fd_valid,
    output logic        fetch_halted
);
`ifdef FETCH_HALT_STOP_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif
    typedef enum logic {FETCH, HALTED} state_t;
    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        accept;
    logic        halt_hit;
    assign imemaddr  = pc;
    assign pc_plus_4 = pc + 32'd4;
    assign accept    = ihit && state == FETCH && !stall && !redirect;
    // Without the halt option this is constant 0, so the FSM never leaves FETCH.
    assign halt_hit  = HALT_EN && accept && imemload == HALT_INSTR;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc           <= PC_INIT;
            fd_instr     <= '0;
            fd_pc_plus_4 <= '0;
            fd_valid     <= 1'b0;
            state        <= FETCH;
            imemREN      <= 1'b1;
            fetch_halted <= 1'b0;
        end else begin
            pc <= redirect ? (redirect_pc & ~32'd3) : accept ? pc_plus_4 : pc;
            // Stall holds FD unless flush/redirect demands a bubble; a missed or
            // halted cycle loads a bubble (accept is 0).
            if (flush || redirect || !stall) begin
                fd_instr     <= (accept && !flush) ? imemload : '0;
                fd_pc_plus_4 <= (accept && !flush) ? pc_plus_4 : '0;
                fd_valid     <= accept && !flush;
            end
            if (redirect) begin
                state        <= FETCH;
                imemREN      <= 1'b1;
                fetch_halted <= 1'b0;
            end else if (halt_hit) begin
                state        <= HALTED;
                imemREN      <= 1'b0;
                fetch_halted <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus random checks of fetch_stage against a behavioural model.
module tb_fetch_stage;
`ifdef FETCH_HALT_STOP_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif
    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, stall, flush, redirect;
    logic [31:0] imemload, redirect_pc, imemaddr, fd_instr, fd_pc_plus_4;
    logic        imemREN, fd_valid, fetch_halted;
    logic        halt_inj;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halted;

    fetch_stage dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .imemREN(imemREN),
        .imemaddr(imemaddr), .stall(stall), .flush(flush), .redirect(redirect),
        .redirect_pc(redirect_pc), .fd_instr(fd_instr), .fd_pc_plus_4(fd_pc_plus_4),
        .fd_valid(fd_valid), .fetch_halted(fetch_halted)
    );

    always #5 CLK = ~CLK;

    // Instruction memory: address-tagged words (low bits 01, never a HALT),
    // except an injected HALT at 0x40.
    always_comb imemload = (halt_inj && imemaddr == 32'h40) ? 32'hFFFF_FFFF : {imemaddr[31:2], 2'b01};

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (halt_inj && a == 32'h40) ? 32'hFFFF_FFFF : {a[31:2], 2'b01};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".imemaddr"}, imemaddr, m_pc);
        chk({tag, ".fd_instr"}, fd_instr, m_instr);
        chk({tag, ".fd_pc_plus_4"}, fd_pc_plus_4, m_pc4);
        chk({tag, ".fd_valid"}, {31'd0, fd_valid}, {31'd0, m_valid});
        chk({tag, ".imemREN"}, {31'd0, imemREN}, {31'd0, !m_halted});
        chk({tag, ".fetch_halted"}, {31'd0, fetch_halted}, {31'd0, m_halted});
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halted = 0;
    endtask

    task automatic step(input string tag, input logic i, input logic s, input logic f,
                        input logic r, input logic [31:0] rpc);
        logic        acc;
        logic [31:0] w;
        @(negedge CLK);
        ihit = i; stall = s; flush = f; redirect = r; redirect_pc = rpc;
        w   = mem_word(m_pc);
        acc = i && !m_halted && !s && !r;
        if (f || r) begin
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (!s) begin
            m_instr = acc ? w : 0; m_pc4 = acc ? m_pc + 4 : 0; m_valid = acc;
        end
        if (r) m_halted = 0;
        else if (HALT_EN && acc && w == 32'hFFFF_FFFF) m_halted = 1;
        m_pc = r ? {rpc[31:2], 2'b00} : acc ? m_pc + 4 : m_pc;
        @(posedge CLK);
        #1;
        chk_all(tag);
    endtask

    initial begin
        ihit = 0; stall = 0; flush = 0; redirect = 0; redirect_pc = 0; halt_inj = 0;
        nRST = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk_all("reset");
        @(negedge CLK);
        nRST = 1;
        for (int k = 0; k < 4; k++) step("stream", 1, 0, 0, 0, 0);
        chk("pc_at_0x10", imemaddr, 32'h10);
        for (int k = 0; k < 3; k++) step("miss", 0, 0, 0, 0, 0);
        step("miss_fill", 1, 0, 0, 0, 0);
        chk("miss_fill_pc4", fd_pc_plus_4, 32'h14);
        for (int k = 0; k < 3; k++) step("to_0x20", 1, 0, 0, 0, 0);
        chk("pc_at_0x20", imemaddr, 32'h20);
        for (int k = 0; k < 2; k++) step("stall", 1, 1, 0, 0, 0);
        chk("stall_hold_pc4", fd_pc_plus_4, 32'h20);
        step("stall_release", 1, 0, 0, 0, 0);
        chk("after_stall_pc4", fd_pc_plus_4, 32'h24);
        step("redirect", 1, 0, 0, 1, 32'h100);
        chk("redirect_addr", imemaddr, 32'h100);
        step("after_redirect", 1, 0, 0, 0, 0);
        step("flush_stall", 1, 1, 1, 0, 0);
        chk("flush_stall_pc", imemaddr, 32'h104);
        step("redirect_lowbits", 0, 0, 0, 1, 32'h3F);
        chk("lowbits_forced", imemaddr, 32'h3C);
        halt_inj = 1;
        step("pre_halt", 1, 0, 0, 0, 0);
        step("halt_fetch", 1, 0, 0, 0, 0);
        chk("halt_word", fd_instr, 32'hFFFF_FFFF);
        chk("halt_pc4", fd_pc_plus_4, 32'h44);
        for (int k = 0; k < 2; k++) step("post_halt", 1, 0, 0, 0, 0);
        step("halt_flush", 1, 0, 1, 0, 0);
        step("resume", 1, 0, 0, 1, 32'h80);
        chk("resume_addr", imemaddr, 32'h80);
        step("resume_fetch", 1, 0, 0, 0, 0);
        halt_inj = 0;
        step("to_top", 0, 0, 0, 1, 32'hFFFF_FFFC);
        step("wrap", 1, 0, 0, 0, 0);
        chk("wrap_pc", imemaddr, 32'h0);
        chk("wrap_pc4", fd_pc_plus_4, 32'h0);
        step("pre_reset", 1, 0, 0, 0, 0);
        step("stall_mid", 1, 1, 0, 0, 0);
        @(negedge CLK);
        stall = 1;
        #2 nRST = 0;
        #1;
        model_reset();
        chk_all("async_reset");
        @(negedge CLK);
        nRST = 1;
        step("after_reset", 1, 0, 0, 0, 0);
        for (int k = 0; k < 400; k++)
            step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline, including the IF/ID (FD) latch it drives. It owns the program counter, issues instruction reads to the icache, and registers each fetched instruction with its PC+4 into the FD latch. It honours stall, flush and redirect requests from the hazard unit and the EX-stage branch/jump resolution. `fd_instr` and `fd_pc_plus_4` map directly onto the `FD_t` fields `instr` and `pc_plus_4` consumed by decode.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded at reset
- HALT_INSTR, 32'hFFFF_FFFF, encoding treated as HALT (used only with FETCH_HALT_STOP_EN)

Ports:
- CLK  in  1  pipeline clock; all state updates on rising edge
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  icache: `imemload` valid for `imemaddr` this cycle
- imemload  in  32  icache read data
- imemREN  out  1  icache read enable
- imemaddr  out  32  icache address (= PC)
- stall  in  1  hazard unit: hold PC and FD latch
- flush  in  1  hazard unit: replace FD contents with a bubble
- redirect  in  1  EX resolution: taken branch / jump / jr (single-cycle pulse)
- redirect_pc  in  32  target PC, word aligned
- fd_instr  out  32  FD latch instruction
- fd_pc_plus_4  out  32  FD latch PC+4
- fd_valid  out  1  FD latch holds a real instruction
- fetch_halted  out  1  fetch stopped on HALT

## Operation
- State: `pc` (32b), FD latch {instr, pc_plus_4, valid}, FSM {FETCH, HALTED}.
- Reset values: `pc`=PC_INIT, `fd_instr`=0, `fd_pc_plus_4`=0, `fd_valid`=0, FSM=FETCH, `imemREN`=1, `fetch_halted`=0.
- `imemaddr` = `pc` (combinational). `imemREN` = 1 in FETCH, 0 in HALTED.
- `accept` = `ihit` & FETCH & !`stall` & !`redirect`.
- PC update, highest priority first:
  - `redirect` → `redirect_pc`.
  - `stall` → hold.
  - `accept` → `pc`+4, 32-bit wrap (0xFFFF_FFFC+4 = 0).
  - Otherwise → hold.
- FD update, highest priority first:
  - `flush` or `redirect` → bubble (instr=0, pc_plus_4=0, valid=0).
  - `stall` → hold.
  - `accept` → {`imemload`, `pc`+4, 1}.
  - Otherwise (miss or HALTED) → bubble.
- Simultaneous cases:
  - `ihit` with `redirect`: fetched word discarded.
  - `ihit` with `stall`: word discarded and refetched next cycle (no skid buffer).
  - `flush` with `stall`: flush wins for FD; PC holds.
- `redirect_pc` low 2 bits are ignored and forced to 0.
- Reset mid-miss or mid-stall: all state returns to reset values immediately. The next fetch is PC_INIT.

## Timing
- Fetch latency: `ihit` in cycle N → `fd_*` valid in cycle N+1.
- Redirect: `redirect` in cycle N → `imemaddr`=`redirect_pc` in N+1; FD holds a bubble in N+1.
- Back-to-back hits: one instruction per cycle.
- No combinational path from `ihit`/`stall`/`flush` to `imemaddr`.
- `imemREN` depends only on FSM state.

## Configuration
- FETCH_HALT_STOP_EN defined:
  - An accepted word equal to HALT_INSTR enters FD normally and moves FSM FETCH→HALTED.
  - `pc` = halt PC+4.
  - In HALTED: `imemREN`=0, `fetch_halted`=1, PC frozen, FD loads bubbles.
  - `redirect` returns to FETCH with `pc`=`redirect_pc`, covering a HALT in the branch shadow.
  - `flush` alone does not leave HALTED.
- FETCH_HALT_STOP_EN undefined:
  - FSM is fixed in FETCH and `fetch_halted` is tied 0.
  - HALT is fetched like any word; fetch continues past it, and halt is handled downstream.

## Test plan
- Reset release with `ihit`=1 every cycle, imem returns addr-tagged words → `imemaddr` 0,4,8,…; `fd_pc_plus_4` 4,8,12,…; `fd_valid`=1 from the second cycle.
- `ihit` low 3 cycles at PC=0x10 → `imemaddr` holds 0x10; FD shows 3 bubbles; the word then loads with `fd_pc_plus_4`=0x14.
- `stall` 2 cycles with `ihit`=1 at PC=0x20 → FD holds the prior instruction; PC stays 0x20; the word at 0x20 enters FD the cycle after `stall` drops.
- `redirect`=1, `redirect_pc`=0x100 with `ihit`=1 at PC=0x24 → FD bubble next cycle; `imemaddr`=0x100; the 0x24 word is never latched.
- `flush` and `stall` together → `fd_valid`=0, `fd_instr`=0; PC unchanged.
- With FETCH_HALT_STOP_EN, 0xFFFFFFFF at 0x40 → FD gets HALT with `fd_pc_plus_4`=0x44, then `imemREN`=0 and `fetch_halted`=1. A following `redirect` to 0x80 resumes fetch at 0x80. Without the macro, fetch continues at 0x44.
